blaster_tx_arbiter: RTL and testbench
=====================================

Name: blaster_tx_arbiter

Overview:
- Shares one UART byte transmitter among NUM_REQ requesters, e.g. the JTAG readback path, the status reporter and the debug console.
- Round-robin arbitration per packet: the granted requester owns the transmitter until it sends a byte flagged last.
- Sequences the engine with a start/done handshake and a watchdog that recovers from a hung engine.
- Sits between the requesters and the tx engine inside the blaster UART subsystem.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT_CLKS, 65535, maximum cycles allowed from tx_start to engine idle. Must exceed 10*CLKS_PER_BIT+4.
- CNT_W, 16, watchdog counter width. Must satisfy 2^CNT_W > TIMEOUT_CLKS.

Ports:
- i_clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- i_req_valid  in  NUM_REQ  requester k has a byte ready.
- i_req_data  in  8*NUM_REQ  byte of requester k in bits [8k+7:8k].
- i_req_last  in  NUM_REQ  byte of requester k ends its packet.
- o_req_ready  out  NUM_REQ  one-cycle pulse: byte of requester k accepted.
- o_grant  out  NUM_REQ  one-hot current owner; all zero when no owner.
- o_tx_start  out  1  one-cycle start pulse to the tx engine.
- o_tx_data  out  8  byte to the tx engine, held stable from START until return to IDLE.
- i_tx_done  in  1  engine done; high for one or more cycles at end of frame.
- o_busy  out  1  high in every state except IDLE.
- o_timeout  out  1  one-cycle pulse when the watchdog fires.

Behaviour:
- Reset (synchronous, active-high) sets:
  - state=IDLE, all outputs 0, o_tx_data=0;
  - lock=0, last_ptr=NUM_REQ-1, so index 0 has first priority;
  - watchdog counter=0.
- All outputs are registered.
- States: IDLE, START, WAIT_DONE, WAIT_IDLE.
- IDLE:
  - If lock=0: winner = first k with i_req_valid[k]=1, searching last_ptr+1, last_ptr+2, ... modulo NUM_REQ.
  - If lock=1: only the locked owner is eligible; the arbiter waits in IDLE with o_grant held, indefinitely and with no watchdog.
  - On a winner: latch data into o_tx_data, latch i_req_last[k] into last_flag, set o_grant=onehot(k), go to START.
  - With no winner and lock=0: o_grant=0.
- START (exactly 1 cycle):
  - o_tx_start=1 and o_req_ready[k]=1 in the same cycle.
  - The requester's byte is consumed at the edge ending START; the requester must hold valid/data stable until then.
  - Watchdog cleared. Go to WAIT_DONE.
- WAIT_DONE:
  - Increment watchdog every cycle.
  - On i_tx_done=1, go to WAIT_IDLE.
- WAIT_IDLE:
  - Keep incrementing watchdog; wait for i_tx_done=0, meaning the engine is back idle.
  - Then, if last_flag=1: lock=0, last_ptr=k, o_grant=0.
  - Else: lock=1, o_grant kept.
  - Go to IDLE.
- Latency:
  - valid seen in IDLE gives ready/start on the next cycle.
  - Back-to-back bytes: one IDLE cycle after i_tx_done falls, then START.
- Watchdog:
  - In WAIT_DONE/WAIT_IDLE, when counter reaches TIMEOUT_CLKS-1 without completion: o_timeout=1 for one cycle, lock=0, last_ptr=k, o_grant=0, go to IDLE.
  - The byte is counted as sent; it is not retried.
- Simultaneous events:
  - valid on several requesters: round-robin decides; only one ready pulse per byte.
  - i_tx_done already high on entry to WAIT_DONE: that is accepted as completion. WAIT_IDLE still waits for the fall, so a stale done never starts a new byte.
  - Requester drops valid while granted and unlocked: it is simply not selected; no ready is issued.
- Reset mid-operation:
  - Immediate return to the reset values; any partial packet is abandoned and the lock is released.
  - The tx engine shares the same reset through an inverter, so both restart together.
- o_req_ready and o_tx_start are never high outside START.

Test Plan:
- Single byte: req1 valid, data 0x5A, last=1, in IDLE → next cycle o_tx_start=1, o_req_ready=0010, o_tx_data=0x5A, o_grant=0010. After done pulse then low → o_grant=0000, o_busy=0.
- Round-robin: all four requesters valid continuously, each byte last=1 → grant order 0,1,2,3,0. Exactly one ready pulse per START.
- Packet lock: req2 sends 3 bytes (last on 3rd) while req0 and req3 are valid → all 3 bytes go out before any other grant. Next grant is req3, then req0. A 10-cycle valid gap on req2 mid-packet keeps o_grant=0100.
- Timeout: TIMEOUT_CLKS=20, i_tx_done held 0 → o_timeout pulses exactly 20 cycles after START. Lock released; the next requester is granted.
- Stale done: i_tx_done held high through START and for 5 cycles after → completion taken once. No second o_tx_start until done falls and one IDLE cycle passes.
- Reset in WAIT_DONE with lock=1 → next cycle all outputs 0. The first grant afterwards goes to req0 when all are valid.

Source files
------------

// File: rtl/blaster_tx_arbiter.sv
// ---------------------------------------------------------------------------
// blaster_tx_arbiter
//
// Shares one UART byte transmitter among NUM_REQ requesters. Arbitration is
// round-robin per packet: once a requester wins, it keeps the transmitter
// until it sends a byte flagged "last". Each byte is handed to the tx engine
// with a start pulse. The arbiter then waits for done to rise and fall again.
// A watchdog abandons the byte if the engine hangs.
//
// Ports:
//   i_clk        system clock
//   reset        synchronous active-high reset
//   i_req_valid  per-requester byte-ready flags
//   i_req_data   requester k byte in bits [8k+7:8k]
//   i_req_last   per-requester end-of-packet flags
//   o_req_ready  one-cycle acceptance pulse (only during START)
//   o_grant      one-hot current owner, zero when nobody owns the engine
//   o_tx_start   one-cycle start pulse to the tx engine
//   o_tx_data    byte to the tx engine, stable from START back to IDLE
//   i_tx_done    engine done, high for one or more cycles at end of frame
//   o_busy       high in every state except IDLE
//   o_timeout    one-cycle pulse when the watchdog abandons a byte
// ---------------------------------------------------------------------------
module blaster_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int TIMEOUT_CLKS = 65535,
  parameter int CNT_W        = 16
) (
  input  logic                 i_clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   i_req_valid,
  input  logic [8*NUM_REQ-1:0] i_req_data,
  input  logic [NUM_REQ-1:0]   i_req_last,
  output logic [NUM_REQ-1:0]   o_req_ready,
  output logic [NUM_REQ-1:0]   o_grant,
  output logic                 o_tx_start,
  output logic [7:0]           o_tx_data,
  input  logic                 i_tx_done,
  output logic                 o_busy,
  output logic                 o_timeout
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int SUM_W = IDX_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] WD_LIMIT = CNT_W'(TIMEOUT_CLKS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT_DONE,
    ST_WAIT_IDLE
  } state_t;

  state_t             state_reg, state_next;
  logic               lock_reg, lock_next;
  logic [IDX_W-1:0]   last_ptr_reg, last_ptr_next;
  logic [IDX_W-1:0]   owner_reg, owner_next;
  logic               last_flag_reg, last_flag_next;
  logic [CNT_W-1:0]   wd_reg, wd_next;
  logic [NUM_REQ-1:0] grant_reg, grant_next;
  logic [NUM_REQ-1:0] ready_reg, ready_next;
  logic               start_reg, start_next;
  logic [7:0]         data_reg, data_next;
  logic               busy_reg, busy_next;
  logic               timeout_reg, timeout_next;

  // While a packet is locked only its owner may compete, so the same
  // round-robin search below serves both the open and the locked case.
  logic [NUM_REQ-1:0] eligible;
  logic [7:0]         req_byte [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
    assign req_byte[gi] = i_req_data[8*gi +: 8];
    assign eligible[gi] = i_req_valid[gi] & (~lock_reg | (owner_reg == IDX_W'(gi)));
  end

  // Search last_ptr+1, last_ptr+2, ... (mod NUM_REQ); the first eligible wins.
  logic [SUM_W-1:0]   cand_sum;
  logic [IDX_W-1:0]   win_idx;
  logic               win_found;
  logic [NUM_REQ-1:0] win_onehot;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand_sum  = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand_sum = {1'b0, last_ptr_reg} + SUM_W'(i);
      if (cand_sum >= SUM_W'(NUM_REQ)) begin
        cand_sum = cand_sum - SUM_W'(NUM_REQ);
      end
      if (!win_found && eligible[cand_sum[IDX_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand_sum[IDX_W-1:0];
      end
    end
  end

  assign win_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx;

  // The watchdog compares the incremented value. The abort decision is then
  // taken TIMEOUT_CLKS-1 cycles after START. Because o_timeout is registered,
  // the pulse lands exactly TIMEOUT_CLKS cycles after the start pulse.
  // Completion in the same cycle takes priority over the abort.
  logic [CNT_W-1:0] wd_inc;
  logic             wd_abort;

  assign wd_inc   = wd_reg + CNT_W'(1);
  assign wd_abort = (wd_inc == WD_LIMIT) &&
                    (((state_reg == ST_WAIT_DONE) && !i_tx_done) ||
                     ((state_reg == ST_WAIT_IDLE) &&  i_tx_done));

  // State register, plus the registered outputs and the arbitration state.
  always_ff @(posedge i_clk) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      lock_reg      <= 1'b0;
      last_ptr_reg  <= LAST_IDX;
      owner_reg     <= '0;
      last_flag_reg <= 1'b0;
      wd_reg        <= '0;
      grant_reg     <= '0;
      ready_reg     <= '0;
      start_reg     <= 1'b0;
      data_reg      <= 8'h00;
      busy_reg      <= 1'b0;
      timeout_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      lock_reg      <= lock_next;
      last_ptr_reg  <= last_ptr_next;
      owner_reg     <= owner_next;
      last_flag_reg <= last_flag_next;
      wd_reg        <= wd_next;
      grant_reg     <= grant_next;
      ready_reg     <= ready_next;
      start_reg     <= start_next;
      data_reg      <= data_next;
      busy_reg      <= busy_next;
      timeout_reg   <= timeout_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (win_found) state_next = ST_START;
      end
      ST_START: begin
        state_next = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        // A done that is already high on entry counts as completion.
        if (i_tx_done)     state_next = ST_WAIT_IDLE;
        else if (wd_abort) state_next = ST_IDLE;
      end
      ST_WAIT_IDLE: begin
        // Wait for done to fall, so a stale done cannot launch the next byte.
        if (!i_tx_done)    state_next = ST_IDLE;
        else if (wd_abort) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Output and datapath logic. Each output is computed one cycle ahead,
  // so its register holds the value that belongs to state_next.
  always_comb begin
    lock_next      = lock_reg;
    last_ptr_next  = last_ptr_reg;
    owner_next     = owner_reg;
    last_flag_next = last_flag_reg;
    wd_next        = wd_reg;
    grant_next     = grant_reg;
    ready_next     = '0;
    start_next     = 1'b0;
    data_next      = data_reg;
    timeout_next   = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (win_found) begin
          data_next      = req_byte[win_idx];
          last_flag_next = i_req_last[win_idx];
          owner_next     = win_idx;
          grant_next     = win_onehot;
          ready_next     = win_onehot;
          start_next     = 1'b1;
        end else if (!lock_reg) begin
          grant_next = '0;
        end
      end
      ST_START: begin
        wd_next = '0;
      end
      ST_WAIT_DONE: begin
        wd_next = wd_inc;
      end
      ST_WAIT_IDLE: begin
        wd_next = wd_inc;
        if (!i_tx_done) begin
          if (last_flag_reg) begin
            lock_next     = 1'b0;
            last_ptr_next = owner_reg;
            grant_next    = '0;
          end else begin
            lock_next = 1'b1;
          end
        end
      end
      default: ;
    endcase

    // A hung byte counts as sent: release the packet and move the pointer on.
    if (wd_abort) begin
      timeout_next  = 1'b1;
      lock_next     = 1'b0;
      last_ptr_next = owner_reg;
      grant_next    = '0;
    end

    busy_next = (state_next != ST_IDLE);
  end

  assign o_req_ready = ready_reg;
  assign o_grant     = grant_reg;
  assign o_tx_start  = start_reg;
  assign o_tx_data   = data_reg;
  assign o_busy      = busy_reg;
  assign o_timeout   = timeout_reg;

endmodule

// File: tb/tb_blaster_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_blaster_tx_arbiter
//
// Directed-vector bench for blaster_tx_arbiter. It uses NUM_REQ=4 and
// TIMEOUT_CLKS=20. Inputs change 1 ns after the rising edge, and outputs are
// read at that same point, so they reflect the edge that just happened.
// ---------------------------------------------------------------------------
module tb_blaster_tx_arbiter;

  logic        i_clk;
  logic        reset;
  logic [3:0]  i_req_valid;
  logic [31:0] i_req_data;
  logic [3:0]  i_req_last;
  logic [3:0]  o_req_ready;
  logic [3:0]  o_grant;
  logic        o_tx_start;
  logic [7:0]  o_tx_data;
  logic        i_tx_done;
  logic        o_busy;
  logic        o_timeout;

  int total = 0;
  int bad   = 0;

  blaster_tx_arbiter #(
    .NUM_REQ      (4),
    .TIMEOUT_CLKS (20),
    .CNT_W        (16)
  ) dut (
    .i_clk       (i_clk),
    .reset       (reset),
    .i_req_valid (i_req_valid),
    .i_req_data  (i_req_data),
    .i_req_last  (i_req_last),
    .o_req_ready (o_req_ready),
    .o_grant     (o_grant),
    .o_tx_start  (o_tx_start),
    .o_tx_data   (o_tx_data),
    .i_tx_done   (i_tx_done),
    .o_busy      (o_busy),
    .o_timeout   (o_timeout)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    i_req_valid = 4'b0000;
    i_req_last  = 4'b0000;
    i_tx_done   = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Advance until a start pulse is visible, bounded to 30 cycles.
  task automatic wait_start(output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (o_tx_start !== 1'b1 && cyc < 30);
    if (o_tx_start === 1'b1)
      $display("txn: start grant=%b ready=%b data=%h at %0t", o_grant, o_req_ready, o_tx_data, $time);
  endtask

  // Called with WAIT_DONE visible; returns with the arbiter back in IDLE.
  task automatic send_done();
    i_tx_done = 1'b1;
    tick();
    i_tx_done = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    i_req_data = 32'h0;
    do_reset();
    total++; if (o_grant !== 4'b0000) begin bad++; $display("FAIL reset_grant: got %b want 0000", o_grant); end
    total++; if (o_tx_start !== 1'b0) begin bad++; $display("FAIL reset_start: got %b want 0", o_tx_start); end
    total++; if (o_req_ready !== 4'b0000) begin bad++; $display("FAIL reset_ready: got %b want 0000", o_req_ready); end
    total++; if (o_tx_data !== 8'h00) begin bad++; $display("FAIL reset_data: got %h want 00", o_tx_data); end
    total++; if (o_busy !== 1'b0 || o_timeout !== 1'b0) begin bad++; $display("FAIL reset_busy_timeout: got %b%b want 00", o_busy, o_timeout); end
  endtask

  task automatic test_single_byte();
    int cyc;
    i_req_data  = 32'h00005A00;
    i_req_last  = 4'b0010;
    i_req_valid = 4'b0010;
    wait_start(cyc);
    total++; if (cyc != 1) begin bad++; $display("FAIL single_latency: got %0d want 1", cyc); end
    total++; if (o_tx_start !== 1'b1) begin bad++; $display("FAIL single_start: got %b want 1", o_tx_start); end
    total++; if (o_req_ready !== 4'b0010) begin bad++; $display("FAIL single_ready: got %b want 0010", o_req_ready); end
    total++; if (o_tx_data !== 8'h5A) begin bad++; $display("FAIL single_data: got %h want 5a", o_tx_data); end
    total++; if (o_grant !== 4'b0010) begin bad++; $display("FAIL single_grant: got %b want 0010", o_grant); end
    tick();
    i_req_valid = 4'b0000;
    total++; if (o_tx_start !== 1'b0 || o_req_ready !== 4'b0000) begin bad++; $display("FAIL single_pulse_width: got start=%b ready=%b want 0 0000", o_tx_start, o_req_ready); end
    total++; if (o_busy !== 1'b1 || o_grant !== 4'b0010) begin bad++; $display("FAIL single_wait: got busy=%b grant=%b want 1 0010", o_busy, o_grant); end
    send_done();
    total++; if (o_grant !== 4'b0000) begin bad++; $display("FAIL single_release: got %b want 0000", o_grant); end
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL single_idle_busy: got %b want 0", o_busy); end
  endtask

  task automatic test_round_robin();
    int cyc;
    logic [3:0] exp_g;
    logic [7:0] exp_d;
    do_reset();
    i_req_data  = 32'h13121110;
    i_req_last  = 4'b1111;
    i_req_valid = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      exp_g = 4'b0001 << (n % 4);
      exp_d = 8'h10 + 8'(n % 4);
      wait_start(cyc);
      total++; if (cyc != 1) begin bad++; $display("FAIL rr_latency[%0d]: got %0d want 1", n, cyc); end
      total++; if (o_grant !== exp_g) begin bad++; $display("FAIL rr_grant[%0d]: got %b want %b", n, o_grant, exp_g); end
      total++; if (o_req_ready !== exp_g) begin bad++; $display("FAIL rr_ready[%0d]: got %b want %b", n, o_req_ready, exp_g); end
      total++; if (o_tx_data !== exp_d) begin bad++; $display("FAIL rr_data[%0d]: got %h want %h", n, o_tx_data, exp_d); end
      tick();
      total++; if (o_req_ready !== 4'b0000 || o_tx_start !== 1'b0) begin bad++; $display("FAIL rr_one_pulse[%0d]: got ready=%b start=%b want 0000 0", n, o_req_ready, o_tx_start); end
      send_done();
    end
    i_req_valid = 4'b0000;
  endtask

  task automatic test_packet_lock();
    int cyc;
    do_reset();
    i_req_data  = 32'h30A0220F;
    i_req_last  = 4'b1001;
    i_req_valid = 4'b0100;
    wait_start(cyc);
    total++; if (o_grant !== 4'b0100 || o_tx_data !== 8'hA0) begin bad++; $display("FAIL lock_b0: got grant=%b data=%h want 0100 a0", o_grant, o_tx_data); end
    tick();
    i_req_valid = 4'b1101;
    i_req_data[23:16] = 8'hA1;
    send_done();
    total++; if (o_grant !== 4'b0100) begin bad++; $display("FAIL lock_hold_idle: got %b want 0100", o_grant); end
    wait_start(cyc);
    total++; if (cyc != 1 || o_grant !== 4'b0100 || o_tx_data !== 8'hA1) begin bad++; $display("FAIL lock_b1: got cyc=%0d grant=%b data=%h want 1 0100 a1", cyc, o_grant, o_tx_data); end
    tick();
    i_req_valid = 4'b1001;
    send_done();
    for (int g = 0; g < 10; g++) begin
      tick();
      total++; if (o_grant !== 4'b0100 || o_tx_start !== 1'b0) begin bad++; $display("FAIL lock_gap[%0d]: got grant=%b start=%b want 0100 0", g, o_grant, o_tx_start); end
    end
    i_req_valid = 4'b1101;
    i_req_data[23:16] = 8'hA2;
    i_req_last = 4'b1101;
    wait_start(cyc);
    total++; if (cyc != 1 || o_grant !== 4'b0100 || o_tx_data !== 8'hA2) begin bad++; $display("FAIL lock_b2: got cyc=%0d grant=%b data=%h want 1 0100 a2", cyc, o_grant, o_tx_data); end
    tick();
    i_req_valid = 4'b1001;
    send_done();
    total++; if (o_grant !== 4'b0000) begin bad++; $display("FAIL lock_release: got %b want 0000", o_grant); end
    wait_start(cyc);
    total++; if (o_grant !== 4'b1000 || o_tx_data !== 8'h30) begin bad++; $display("FAIL lock_next3: got grant=%b data=%h want 1000 30", o_grant, o_tx_data); end
    tick();
    send_done();
    wait_start(cyc);
    total++; if (o_grant !== 4'b0001 || o_tx_data !== 8'h0F) begin bad++; $display("FAIL lock_next0: got grant=%b data=%h want 0001 0f", o_grant, o_tx_data); end
    tick();
    i_req_valid = 4'b0000;
    send_done();
  endtask

  task automatic test_timeout();
    int cyc;
    int early;
    do_reset();
    i_req_data  = 32'h00007700;
    i_req_last  = 4'b0000;
    i_req_valid = 4'b0010;
    wait_start(cyc);
    total++; if (o_grant !== 4'b0010) begin bad++; $display("FAIL to_grant: got %b want 0010", o_grant); end
    early = 0;
    for (int k = 1; k <= 21; k++) begin
      tick();
      if (k == 1) i_req_valid = 4'b0000;
      if (k < 20) begin
        if (o_timeout !== 1'b0) early++;
      end else if (k == 20) begin
        total++; if (o_timeout !== 1'b1) begin bad++; $display("FAIL to_pulse: got %b want 1 at 20 cycles", o_timeout); end
        total++; if (o_grant !== 4'b0000) begin bad++; $display("FAIL to_grant_clear: got %b want 0000", o_grant); end
      end else begin
        total++; if (o_timeout !== 1'b0) begin bad++; $display("FAIL to_one_cycle: got %b want 0", o_timeout); end
        total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL to_idle: got busy=%b want 0", o_busy); end
      end
    end
    total++; if (early != 0) begin bad++; $display("FAIL to_early: got %0d early pulses want 0", early); end
    i_req_data  = 32'h33221100;
    i_req_last  = 4'b1111;
    i_req_valid = 4'b1111;
    wait_start(cyc);
    total++; if (o_grant !== 4'b0100 || o_tx_data !== 8'h22) begin bad++; $display("FAIL to_next_grant: got grant=%b data=%h want 0100 22", o_grant, o_tx_data); end
    tick();
    i_req_valid = 4'b0000;
    send_done();
  endtask

  task automatic test_stale_done();
    int cyc;
    do_reset();
    i_req_data  = 32'h0000443C;
    i_req_last  = 4'b0011;
    i_req_valid = 4'b0001;
    i_tx_done   = 1'b1;
    wait_start(cyc);
    total++; if (o_grant !== 4'b0001 || o_tx_data !== 8'h3C) begin bad++; $display("FAIL stale_first: got grant=%b data=%h want 0001 3c", o_grant, o_tx_data); end
    for (int s = 0; s < 5; s++) begin
      tick();
      if (s == 0) i_req_valid = 4'b0010;
      total++; if (o_tx_start !== 1'b0 || o_busy !== 1'b1) begin bad++; $display("FAIL stale_hold[%0d]: got start=%b busy=%b want 0 1", s, o_tx_start, o_busy); end
    end
    i_tx_done = 1'b0;
    tick();
    total++; if (o_busy !== 1'b0 || o_tx_start !== 1'b0 || o_grant !== 4'b0000) begin bad++; $display("FAIL stale_idle: got busy=%b start=%b grant=%b want 0 0 0000", o_busy, o_tx_start, o_grant); end
    tick();
    total++; if (o_tx_start !== 1'b1 || o_grant !== 4'b0010 || o_tx_data !== 8'h44) begin bad++; $display("FAIL stale_second: got start=%b grant=%b data=%h want 1 0010 44", o_tx_start, o_grant, o_tx_data); end
    tick();
    i_req_valid = 4'b0000;
    send_done();
  endtask

  task automatic test_reset_mid();
    int cyc;
    do_reset();
    i_req_data  = 32'h44336155;
    i_req_last  = 4'b0000;
    i_req_valid = 4'b0010;
    wait_start(cyc);
    tick();
    send_done();
    wait_start(cyc);
    total++; if (o_grant !== 4'b0010 || o_tx_start !== 1'b1) begin bad++; $display("FAIL rmid_second: got grant=%b start=%b want 0010 1", o_grant, o_tx_start); end
    tick();
    reset       = 1'b1;
    i_req_valid = 4'b1111;
    i_req_last  = 4'b1111;
    tick();
    total++; if (o_grant !== 4'b0000 || o_tx_start !== 1'b0 || o_req_ready !== 4'b0000) begin bad++; $display("FAIL rmid_zero: got grant=%b start=%b ready=%b want 0000 0 0000", o_grant, o_tx_start, o_req_ready); end
    total++; if (o_tx_data !== 8'h00 || o_busy !== 1'b0 || o_timeout !== 1'b0) begin bad++; $display("FAIL rmid_zero2: got data=%h busy=%b timeout=%b want 00 0 0", o_tx_data, o_busy, o_timeout); end
    reset = 1'b0;
    wait_start(cyc);
    total++; if (o_grant !== 4'b0001 || o_tx_data !== 8'h55) begin bad++; $display("FAIL rmid_first_grant: got grant=%b data=%h want 0001 55", o_grant, o_tx_data); end
    tick();
    i_req_valid = 4'b0000;
    send_done();
  endtask

  initial begin
    reset       = 1'b1;
    i_req_valid = 4'b0000;
    i_req_data  = 32'h0;
    i_req_last  = 4'b0000;
    i_tx_done   = 1'b0;
    test_reset();
    test_single_byte();
    test_round_robin();
    test_packet_lock();
    test_timeout();
    test_stale_done();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
